fft_dmem_mp: RTL and testbench
==============================

Name: fft_dmem_mp

Overview:
- Parametrised multi-lane data scratchpad for the FFT MCU datapath. It replaces the fixed 8-port, 16-bit, ready-gated ROM/RAM data memory.
- Provides LANES independent read/write lanes over one shared register array, with registered reads and deterministic write-collision priority.
- A sequential loader copies an external sample ROM into the array under a start/busy/done handshake.
- Maintains an out-of-bounds error flag and a result-region parity flag for completion checking by the MCU.

Parameters:
- LANES, 8, number of read/write lanes
- DW, 16, data width per entry in bits
- DEPTH, 64, number of entries; index width IW = $clog2(DEPTH)
- ROM_WORDS, 16, number of words copied by the loader
- ROM_BASE, 0, first array index written by the loader
- RES_BASE, 32, first index of the result region covered by parity
- RES_WORDS, 16, number of entries in the result region

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  LANES  per-lane write enable, high active
- addr  in  LANES*32  per-lane byte address, lane i = addr[32*i+:32]; entry index = addr[IW:1]
- wdata  in  LANES*DW  per-lane write data
- rdata  out  LANES*DW  per-lane registered read data
- load_start  in  1  single-cycle pulse that starts a ROM copy
- load_busy  out  1  high while the loader owns the array
- load_done  out  1  one-cycle pulse after the last ROM word is written
- rom_addr  out  $clog2(ROM_WORDS)  address to the external combinational ROM
- rom_data  in  DW  ROM read data, valid in the same cycle as rom_addr
- err_oob  out  1  sticky flag: some lane accessed out of bounds
- res_parity  out  1  XOR of bit 0 over RES_WORDS result entries

Behaviour:
- Reset (async, rst_n=0):
  - All array entries = 0; rdata = 0; load_busy = 0; load_done = 0; rom_addr = 0; err_oob = 0; res_parity = 0.
  - FSM goes to IDLE. Reset during LOAD aborts the copy and leaves no partial state.
- Out of bounds: a lane access is OOB when addr[31:IW+1] != 0 or index >= DEPTH.
  - An OOB write is dropped. An OOB read returns 0.
  - Any OOB access with we=1, or any OOB read while IDLE, sets err_oob. err_oob clears only on reset.
- Reads:
  - Latency is 1 cycle: rdata lane i at cycle t+1 = array[index_i] as sampled at cycle t.
  - Read-first: a same-cycle write to the same index is not visible until the next access.
- Writes:
  - Take effect at the rising edge when we[i]=1, the FSM is IDLE, and the access is in bounds.
  - Collision: if several lanes write the same index in one cycle, the highest lane number wins.
- FSM states IDLE, LOAD, DONE:
  - IDLE: load_start=1 -> LOAD with cnt=0.
  - LOAD: each cycle rom_addr=cnt and array[ROM_BASE+cnt] <= rom_data; cnt increments. When cnt = ROM_WORDS-1 -> DONE.
  - DONE: load_done=1 for exactly one cycle -> IDLE.
  - load_busy = 1 in LOAD and DONE.
  - A ROM copy of ROM_WORDS words takes ROM_WORDS+1 cycles from load_start to load_done, inclusive of the DONE cycle.
- While load_busy=1:
  - Lane writes are ignored.
  - Lane rdata is forced to 0 in the following cycle.
  - load_start is ignored; no re-trigger occurs.
- Parity: res_parity is registered every cycle as XOR of array[RES_BASE+k][0] for k=0..RES_WORDS-1. It lags an array change by 1 cycle.
- Elaboration checks: ROM_BASE+ROM_WORDS <= DEPTH, RES_BASE+RES_WORDS <= DEPTH, DW >= 1, LANES >= 1.

Optional Feature:
- Macro: DMEM_WRITE_FORWARD_EN.
- When defined: reads are write-first. If an in-bounds write to the same index, by the winning lane, happens in the same cycle as a read, rdata for every reading lane at t+1 equals that write data. During LOAD, forwarding does not apply (rdata stays 0).
- When undefined: read-first behaviour as specified above. No forwarding mux is synthesised.

Test Plan:
- Reset then idle read: rst_n low for 3 cycles, then all lanes read index 5 -> rdata = 0 on every lane; err_oob=0; res_parity=0.
- Load: ROM holds k+0x100 at word k; pulse load_start -> load_busy high for 17 cycles; load_done pulses exactly once. Lane 0 then reads index 3 -> 0x0103 one cycle later.
- Collision: lanes 2, 5 and 7 write index 40 with 0x0001, 0x0002 and 0x0003 in one cycle -> next-cycle read of index 40 = 0x0003. res_parity toggles to 1 one cycle after the write.
- Read-first: lane 1 writes 0xBEEF to index 20 (old value 0x1234) while lane 4 reads index 20 -> lane 4 rdata = 0x1234. With DMEM_WRITE_FORWARD_EN defined, lane 4 rdata = 0xBEEF.
- OOB: lane 6 writes byte address 0x0000_0200 -> array unchanged; err_oob rises the next edge and stays high until reset.
- Reset mid-load: assert rst_n=0 in load cycle 8 -> load_busy=0 and load_done never pulses; all entries read 0 after release. A new load_start completes normally.

Source files
------------

// File: rtl/fft_dmem_mp.sv
// Multi-lane FFT data scratchpad: shared register array, registered reads, ROM loader, OOB and parity flags.
// Optional write-first read forwarding is enabled by defining DMEM_WRITE_FORWARD_EN.
module fft_dmem_mp #(
    parameter int LANES     = 8,
    parameter int DW        = 16,
    parameter int DEPTH     = 64,
    parameter int ROM_WORDS = 16,
    parameter int ROM_BASE  = 0,
    parameter int RES_BASE  = 32,
    parameter int RES_WORDS = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [LANES-1:0]             we,
    input  logic [LANES*32-1:0]          addr,
    input  logic [LANES*DW-1:0]          wdata,
    output logic [LANES*DW-1:0]          rdata,
    input  logic                         load_start,
    output logic                         load_busy,
    output logic                         load_done,
    output logic [$clog2(ROM_WORDS)-1:0] rom_addr,
    input  logic [DW-1:0]                rom_data,
    output logic                         err_oob,
    output logic                         res_parity
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(ROM_WORDS);
    localparam logic [IW:0]   DEPTH_W    = (IW+1)'(DEPTH);
    localparam logic [IW-1:0] ROM_BASE_I = IW'(ROM_BASE);
    localparam logic [CW-1:0] CNT_LAST   = CW'(ROM_WORDS - 1);

    if (ROM_BASE + ROM_WORDS > DEPTH) begin : g_chk_rom
        $error("fft_dmem_mp: ROM copy region exceeds DEPTH");
    end
    if (RES_BASE + RES_WORDS > DEPTH) begin : g_chk_res
        $error("fft_dmem_mp: result region exceeds DEPTH");
    end
    if (DW < 1 || LANES < 1) begin : g_chk_dims
        $error("fft_dmem_mp: DW and LANES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [DW-1:0] mem_t [DEPTH];

    mem_t                  mem_r;
    mem_t                  mem_n;
    state_t                state_r;
    state_t                state_n;
    logic [CW-1:0]         cnt_r;
    logic [CW-1:0]         cnt_n;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;
    logic                  par_r;
    logic [LANES*DW-1:0]   rdata_r;
    logic [LANES*DW-1:0]   rdata_n;
    logic [IW-1:0]         idx_s [LANES];
    logic                  inb_s [LANES];
    logic                  oob_hit_s;
    logic [LANES-1:0]      unused_addr_lsb_s;
    logic [31:0]           lane_addr_s;

    function automatic logic res_parity_f(input mem_t m);
        logic p;
        p = 1'b0;
        for (int k = 0; k < RES_WORDS; k++) begin
            p = p ^ m[RES_BASE + k][0];
        end
        return p;
    endfunction

    // Per-lane index extraction, bounds check and error detection
    always_comb begin
        oob_hit_s         = 1'b0;
        unused_addr_lsb_s = '0;
        lane_addr_s       = 32'h0000_0000;
        for (int i = 0; i < LANES; i++) begin
            lane_addr_s          = addr[32*i +: 32];
            unused_addr_lsb_s[i] = lane_addr_s[0];
            idx_s[i]             = lane_addr_s[IW:1];
            inb_s[i]             = (lane_addr_s[31:IW+1] == '0) && ({1'b0, lane_addr_s[IW:1]} < DEPTH_W);
            // writes are flagged in any state; reads only count while lanes own the array
            if (!inb_s[i] && (we[i] || (state_r == IDLE))) begin
                oob_hit_s = 1'b1;
            end else begin
                oob_hit_s = oob_hit_s;
            end
        end
    end

    // Loader FSM next-state and copy counter
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        case (state_r)
            IDLE: begin
                if (load_start) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            LOAD: begin
                cnt_n = cnt_r + CW'(1);
                if (cnt_r == CNT_LAST) begin
                    state_n = DONE;
                end else begin
                    state_n = LOAD;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next array contents: loader owns the array in LOAD, otherwise lanes write in ascending order so the highest lane wins
    always_comb begin
        mem_n = mem_r;
        if (state_r == LOAD) begin
            mem_n[ROM_BASE_I + IW'(cnt_r)] = rom_data;
        end else if (state_r == IDLE) begin
            for (int i = 0; i < LANES; i++) begin
                mem_n[idx_s[i]] = (we[i] && inb_s[i]) ? wdata[DW*i +: DW] : mem_n[idx_s[i]];
            end
        end else begin
            mem_n = mem_r;
        end
    end

    // Read data: zero for OOB lanes and whenever the loader is active
    always_comb begin
        rdata_n = '0;
        for (int i = 0; i < LANES; i++) begin
            if ((state_r == IDLE) && inb_s[i]) begin
`ifdef DMEM_WRITE_FORWARD_EN
                rdata_n[DW*i +: DW] = mem_n[idx_s[i]];
`else
                rdata_n[DW*i +: DW] = mem_r[idx_s[i]];
`endif
            end else begin
                rdata_n[DW*i +: DW] = '0;
            end
        end
    end

    // Storage array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= '{default: '0};
        end else begin
            mem_r <= mem_n;
        end
    end

    // Control, status and read registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            par_r   <= 1'b0;
            rdata_r <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            busy_r  <= (state_n != IDLE);
            done_r  <= (state_n == DONE);
            err_r   <= err_r | oob_hit_s;
            par_r   <= res_parity_f(mem_r);
            rdata_r <= rdata_n;
        end
    end

    assign rdata      = rdata_r;
    assign load_busy  = busy_r;
    assign load_done  = done_r;
    assign rom_addr   = cnt_r;
    assign err_oob    = err_r;
    assign res_parity = par_r;

endmodule

// File: tb/tb_fft_dmem_mp.sv
// Directed self-checking bench for fft_dmem_mp; ROM model returns 0x0100 + word address.
module tb_fft_dmem_mp;

    logic         clk;
    logic         rst_n;
    logic [7:0]   we;
    logic [255:0] addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         load_start;
    logic         load_busy;
    logic         load_done;
    logic [3:0]   rom_addr;
    logic [15:0]  rom_data;
    logic         err_oob;
    logic         res_parity;

    int n_checks = 0;
    int n_pass   = 0;

    fft_dmem_mp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .load_start (load_start),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .err_oob    (err_oob),
        .res_parity (res_parity)
    );

    assign rom_data = 16'h0100 + {12'h000, rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_lane(input int i, input logic w, input logic [31:0] a, input logic [15:0] d);
        we[i]             = w;
        addr[32*i +: 32]  = a;
        wdata[16*i +: 16] = d;
    endtask

    task automatic clear_inputs();
        we         = '0;
        addr       = '0;
        wdata      = '0;
        load_start = 1'b0;
    endtask

    function automatic logic [15:0] lane_rd(input int i);
        return rdata[16*i +: 16];
    endfunction

    initial begin
        int busy_cnt;
        int done_cnt;
        logic [15:0] acc;
        logic done_seen;

        // reset and idle read
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) tick();
        check("rst_rdata", rdata[31:0], 32'h0);
        check("rst_busy", {31'd0, load_busy}, 32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_rom_addr", {28'd0, rom_addr}, 32'd0);
        check("rst_err", {31'd0, err_oob}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) set_lane(i, 1'b0, 32'd10, 16'h0);
        tick();
        for (int i = 0; i < 8; i++) check($sformatf("idle_rd_lane%0d", i), {16'd0, lane_rd(i)}, 32'h0);
        check("idle_err", {31'd0, err_oob}, 32'd0);
        check("idle_parity", {31'd0, res_parity}, 32'd0);

        // ROM load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        busy_cnt = load_busy ? 1 : 0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (!load_busy) break;
            tick();
            if (load_busy) busy_cnt++;
            if (load_done) done_cnt++;
        end
        check("load_busy_len", busy_cnt, 32'd17);
        check("load_done_cnt", done_cnt, 32'd1);
        check("load_busy_end", {31'd0, load_busy}, 32'd0);
        set_lane(0, 1'b0, 32'd6, 16'h0);
        set_lane(1, 1'b0, 32'd10, 16'h0);
        tick();
        check("load_rd_idx3", {16'd0, lane_rd(0)}, 32'h0103);
        check("load_rd_idx5", {16'd0, lane_rd(1)}, 32'h0105);
        check("load_err", {31'd0, err_oob}, 32'd0);

        // collision on index 40
        set_lane(2, 1'b1, 32'd80, 16'h0001);
        set_lane(5, 1'b1, 32'd80, 16'h0002);
        set_lane(7, 1'b1, 32'd80, 16'h0003);
        tick();
        we = '0;
        check("coll_parity_lag", {31'd0, res_parity}, 32'd0);
        set_lane(0, 1'b0, 32'd80, 16'h0);
        tick();
        check("coll_rd", {16'd0, lane_rd(0)}, 32'h0003);
        check("coll_parity", {31'd0, res_parity}, 32'd1);

        // read-first versus forwarding on index 20
        set_lane(3, 1'b1, 32'd40, 16'h1234);
        tick();
        we = '0;
        set_lane(1, 1'b1, 32'd40, 16'hBEEF);
        set_lane(4, 1'b0, 32'd40, 16'h0);
        tick();
        we = '0;
`ifdef DMEM_WRITE_FORWARD_EN
        check("rf_same_cycle", {16'd0, lane_rd(4)}, 32'hBEEF);
`else
        check("rf_same_cycle", {16'd0, lane_rd(4)}, 32'h1234);
`endif
        tick();
        check("rf_next", {16'd0, lane_rd(4)}, 32'hBEEF);

        // out-of-bounds write
        clear_inputs();
        set_lane(6, 1'b1, 32'h0000_0200, 16'hDEAD);
        set_lane(0, 1'b0, 32'd0, 16'h0);
        tick();
        check("oob_err_rise", {31'd0, err_oob}, 32'd1);
        we = '0;
        tick();
        check("oob_array_kept", {16'd0, lane_rd(0)}, 32'h0100);
        check("oob_rd_zero", {16'd0, lane_rd(6)}, 32'h0);
        repeat (3) tick();
        check("oob_err_sticky", {31'd0, err_oob}, 32'd1);

        // reset in the middle of a load
        clear_inputs();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tick();
        tick();
        check("mid_rom_addr", {28'd0, rom_addr}, 32'd2);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, load_busy}, 32'd0);
        check("mid_rst_err", {31'd0, err_oob}, 32'd0);
        check("mid_rst_rom_addr", {28'd0, rom_addr}, 32'd0);
        done_seen = load_done;
        repeat (2) begin
            tick();
            done_seen = done_seen | load_done;
        end
        rst_n = 1'b1;
        acc = 16'h0;
        for (int ch = 0; ch < 8; ch++) begin
            for (int i = 0; i < 8; i++) set_lane(i, 1'b0, 32'((ch*8 + i) * 2), 16'h0);
            tick();
            done_seen = done_seen | load_done;
            for (int i = 0; i < 8; i++) acc = acc | lane_rd(i);
        end
        check("mid_all_zero", {16'd0, acc}, 32'h0);
        check("mid_no_done", {31'd0, done_seen}, 32'd0);
        check("mid_err_clear", {31'd0, err_oob}, 32'd0);

        // fresh load with an ignored re-trigger
        clear_inputs();
        set_lane(0, 1'b0, 32'd6, 16'h0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        busy_cnt = load_busy ? 1 : 0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (!load_busy) break;
            load_start = (busy_cnt == 5);
            tick();
            load_start = 1'b0;
            if (load_busy) busy_cnt++;
            if (load_done) done_cnt++;
            if (busy_cnt == 10) check("busy_rd_zero", {16'd0, lane_rd(0)}, 32'h0);
        end
        check("reload_busy_len", busy_cnt, 32'd17);
        check("reload_done_cnt", done_cnt, 32'd1);
        tick();
        check("reload_no_retrigger", {31'd0, load_busy}, 32'd0);
        set_lane(2, 1'b0, 32'd30, 16'h0);
        set_lane(3, 1'b0, 32'd0, 16'h0);
        tick();
        check("reload_idx3", {16'd0, lane_rd(0)}, 32'h0103);
        check("reload_idx15", {16'd0, lane_rd(2)}, 32'h010F);
        check("reload_idx0", {16'd0, lane_rd(3)}, 32'h0100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
